// File: rtl/serial_to_parallel_rx.sv
// Receive-side deserializer for the 1-bit stream in the clk_32f domain.
// The stream arrives MSB first. The block aligns to byte boundaries on COM_CHAR.
// It locks once BC_COUNT consecutive aligned COM_CHARs have been seen.
// After lock it presents each non-COM byte on data_out and flags it with valid_out.
module serial_to_parallel_rx #(
  parameter logic [7:0] COM_CHAR = 8'hBC,
  parameter int         BC_COUNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active
);

  localparam int               CNT_W   = $clog2(BC_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] BC_LAST = CNT_W'(BC_COUNT);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t           state;
  logic [6:0]       sr;        // only the 7 most recent bits are needed to form the next byte
  logic [7:0]       nsr;
  logic [2:0]       bit_cnt;
  logic [CNT_W-1:0] com_cnt;
  logic [CNT_W-1:0] com_nxt;
  logic             byte_done;
  logic             is_com;

  // Next-shift-register view: every decision is made on the byte including this edge's bit.
  assign nsr       = {sr, data_in};
  assign is_com    = (nsr == COM_CHAR);
  assign byte_done = (bit_cnt == 3'd7);
  assign com_nxt   = com_cnt + CNT_ONE;

  // Alignment FSM, bit/COM counters and registered byte outputs.
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state     <= SEARCH;
      sr        <= '0;
      bit_cnt   <= '0;
      com_cnt   <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      active    <= 1'b0;
    end else begin
      sr <= nsr[6:0];
      case (state)
        SEARCH: begin
          // Slide one bit at a time; a COM match fixes the byte boundary here.
          if (is_com) begin
            bit_cnt <= '0;
            com_cnt <= CNT_ONE;
            if (BC_COUNT == 1) begin
              state  <= LOCKED;
              active <= 1'b1;
            end else begin
              state <= ALIGN;
            end
          end
        end
        ALIGN: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (byte_done) begin
            if (is_com) begin
              com_cnt <= com_nxt;
              if (com_nxt == BC_LAST) begin
                state  <= LOCKED;
                active <= 1'b1;
              end
            end else begin
              // A non-COM byte on the tentative boundary means the match was false.
              state   <= SEARCH;
              com_cnt <= '0;
            end
          end
        end
        LOCKED: begin
          // Lock is sticky until reset; COM bytes only clear the valid flag.
          bit_cnt <= bit_cnt + 3'd1;
          if (byte_done) begin
            if (is_com) begin
              valid_out <= 1'b0;
            end else begin
              data_out  <= nsr;
              valid_out <= 1'b1;
            end
          end
        end
        default: begin
          state   <= SEARCH;
          com_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// Directed bench for serial_to_parallel_rx: lock-up, false alignment, offset
// alignment, COM insertion while locked and asynchronous reset mid-byte.
module tb_serial_to_parallel_rx;

  logic       clk_32f;
  logic       reset;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;

  int n_checks;
  int n_pass;

  serial_to_parallel_rx #(
    .COM_CHAR (8'hBC),
    .BC_COUNT (4)
  ) dut (
    .clk_32f   (clk_32f),
    .reset     (reset),
    .data_in   (data_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .active    (active)
  );

  initial clk_32f = 1'b0;
  always #5 clk_32f = ~clk_32f;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Drive one bit at the falling edge, then sample 1 time unit after the rising edge.
  task automatic send_bit(input logic b);
    @(negedge clk_32f);
    data_in = b;
    @(posedge clk_32f);
    #1;
  endtask

  // Send the top nbits of a byte, MSB first.
  task automatic send_bits(input logic [7:0] b, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) send_bit(b[i]);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(b, 8);
  endtask

  task automatic do_reset();
    @(negedge clk_32f);
    reset   = 1'b0;
    data_in = 1'b0;
    repeat (2) @(negedge clk_32f);
    reset = 1'b1;
  endtask

  task automatic chk_out(input string tag, input logic [7:0] d, input logic v, input logic a);
    chk({tag, ".data"},   {24'h0, data_out}, {24'h0, d});
    chk({tag, ".valid"},  {31'h0, valid_out}, {31'h0, v});
    chk({tag, ".active"}, {31'h0, active}, {31'h0, a});
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b0;
    data_in  = 1'b0;

    // 1. Held in reset with random serial activity: outputs stay cleared.
    for (int i = 0; i < 40; i++) begin
      send_bit(1'($urandom_range(0, 1)));
      chk_out("t1_rst", 8'h00, 1'b0, 1'b0);
    end

    // 2. BC x4 locks on bit 32, then FF on bit 40 held for 8 cycles, then EE on bit 48.
    @(negedge clk_32f);
    reset = 1'b1;
    repeat (3) send_byte(8'hBC);
    chk_out("t2_after3", 8'h00, 1'b0, 1'b0);
    send_bits(8'hBC, 7);
    chk_out("t2_bit31", 8'h00, 1'b0, 1'b0);
    send_bit(1'b0);
    chk_out("t2_bit32", 8'h00, 1'b0, 1'b1);
    send_bits(8'hFF, 7);
    chk_out("t2_bit39", 8'h00, 1'b0, 1'b1);
    send_bit(1'b1);
    chk_out("t2_ff", 8'hFF, 1'b1, 1'b1);
    for (int i = 7; i >= 1; i--) begin
      send_bit(i[0] ? 1'b1 : (i == 4 ? 1'b0 : 1'b1));
      chk_out("t2_hold", 8'hFF, 1'b1, 1'b1);
    end
    send_bit(1'b0);
    chk_out("t2_ee", 8'hEE, 1'b1, 1'b1);

    // 3. A non-COM byte during alignment sends the FSM back to search.
    do_reset();
    send_byte(8'hBC);
    send_byte(8'hBC);
    send_byte(8'hBC);
    chk_out("t3_b3", 8'h00, 1'b0, 1'b0);
    send_byte(8'h11);
    chk_out("t3_b4", 8'h00, 1'b0, 1'b0);
    send_byte(8'hBC);
    chk_out("t3_b5", 8'h00, 1'b0, 1'b0);
    send_byte(8'hBC);
    send_byte(8'hBC);
    chk_out("t3_b7", 8'h00, 1'b0, 1'b0);
    send_byte(8'hBC);
    chk_out("t3_b8", 8'h00, 1'b0, 1'b1);

    // 4. Three junk bits ahead of the COMs: alignment is still found.
    do_reset();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    repeat (3) send_byte(8'hBC);
    chk_out("t4_b3", 8'h00, 1'b0, 1'b0);
    send_byte(8'hBC);
    chk_out("t4_lock", 8'h00, 1'b0, 1'b1);
    send_byte(8'h5A);
    chk_out("t4_5a", 8'h5A, 1'b1, 1'b1);

    // 5. While locked: EE, BC, 22 -> valid 1,0,1 with data retained over the COM.
    send_byte(8'hEE);
    chk_out("t5_ee", 8'hEE, 1'b1, 1'b1);
    send_byte(8'hBC);
    chk_out("t5_bc", 8'hEE, 1'b0, 1'b1);
    send_byte(8'h22);
    chk_out("t5_22", 8'h22, 1'b1, 1'b1);

    // 6. Async reset four bits into a byte clears outputs without a clock edge.
    send_bits(8'h77, 4);
    chk_out("t6_pre", 8'h22, 1'b1, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk_out("t6_async", 8'h00, 1'b0, 1'b0);
    @(negedge clk_32f);
    reset = 1'b1;
    send_byte(8'h33);
    chk_out("t6_33", 8'h00, 1'b0, 1'b0);
    repeat (3) send_byte(8'hBC);
    chk_out("t6_b3", 8'h00, 1'b0, 1'b0);
    send_byte(8'hBC);
    chk_out("t6_lock", 8'h00, 1'b0, 1'b1);
    send_byte(8'h44);
    chk_out("t6_44", 8'h44, 1'b1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
